jedro_1_mem_arbiter: RTL

Shares one data/instruction memory port between two requesters: port 0 = instruction fetch (IFU), port 1 = load-store unit (LSU). Round-robin arbitration on the request channel, grant locked until handshake, and in-order routing of responses back to the issuing port via an outstanding-transaction ID FIFO. Sits between the core's fetch/LSU memory interfaces and the single memory bus.

---
 rtl/jedro_1_mem_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/jedro_1_mem_arbiter.sv
// ---------------------------------------------------------------------------
// jedro_1_mem_arbiter
//
// Shares one memory port between the instruction fetch unit (port 0) and the
// load-store unit (port 1). Requests are arbitrated round-robin and the grant
// is held until the memory accepts it. Responses come back in order and are
// routed to the port that issued them, using a small FIFO of port IDs.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   ifu_req_* / ifu_rsp_*   fetch request (read only) and response channel
//   lsu_req_* / lsu_rsp_*   load-store request and response channel
//   mem_req_* / mem_rsp_*   shared memory bus request and response channel
//   spurious_rsp_o          sticky flag: response seen with nothing outstanding
// ---------------------------------------------------------------------------
module jedro_1_mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] ifu_req_addr_i,
  input  logic                  ifu_req_valid_i,
  output logic                  ifu_req_ready_o,
  output logic [DATA_WIDTH-1:0] ifu_rsp_data_o,
  output logic                  ifu_rsp_error_o,
  output logic                  ifu_rsp_valid_o,
  input  logic                  ifu_rsp_ready_i,
  input  logic [DATA_WIDTH-1:0] lsu_req_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_req_data_i,
  input  logic [3:0]            lsu_req_strobe_i,
  input  logic                  lsu_req_write_i,
  input  logic                  lsu_req_valid_i,
  output logic                  lsu_req_ready_o,
  output logic [DATA_WIDTH-1:0] lsu_rsp_data_o,
  output logic                  lsu_rsp_error_o,
  output logic                  lsu_rsp_valid_o,
  input  logic                  lsu_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] mem_req_addr_o,
  output logic [DATA_WIDTH-1:0] mem_req_data_o,
  output logic [3:0]            mem_req_strobe_o,
  output logic                  mem_req_write_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
  input  logic                  mem_rsp_error_i,
  input  logic                  mem_rsp_valid_i,
  output logic                  mem_rsp_ready_o,
  output logic                  spurious_rsp_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  // Port IDs: 1'b0 = IFU, 1'b1 = LSU.
  logic             lock_r;
  logic             locked_port_r;
  logic             rr_last_r;
  logic             id_fifo_r [MAX_OUTSTANDING];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  logic sel_s;
  logic sel_valid_s;
  logic req_fire_s;
  logic have_out_s;
  logic head_s;
  logic pop_s;

  // Pick the port that drives the memory request this cycle.
  always_comb begin
    sel_s = 1'b0;
    if (lock_r) begin
      // A stalled request must keep its fields stable until accepted.
      sel_s = locked_port_r;
    end else if (ifu_req_valid_i && lsu_req_valid_i) begin
      sel_s = ~rr_last_r;
    end else if (lsu_req_valid_i) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  assign sel_valid_s     = sel_s ? lsu_req_valid_i : ifu_req_valid_i;
  // A full ID FIFO blocks issue even if a response pops in the same cycle.
  assign mem_req_valid_o = sel_valid_s && (count_r < MAX_CNT);
  assign req_fire_s      = mem_req_valid_o && mem_req_ready_i;
  assign ifu_req_ready_o = req_fire_s && !sel_s;
  assign lsu_req_ready_o = req_fire_s && sel_s;

  // Mux the selected port's request fields onto the memory bus; fetches are reads.
  always_comb begin
    if (sel_s) begin
      mem_req_addr_o   = lsu_req_addr_i;
      mem_req_data_o   = lsu_req_data_i;
      mem_req_strobe_o = lsu_req_strobe_i;
      mem_req_write_o  = lsu_req_write_i;
    end else begin
      mem_req_addr_o   = ifu_req_addr_i;
      mem_req_data_o   = {DATA_WIDTH{1'b0}};
      mem_req_strobe_o = 4'b0000;
      mem_req_write_o  = 1'b0;
    end
  end

  assign have_out_s = (count_r != {CNT_W{1'b0}});
  assign head_s     = id_fifo_r[rd_ptr_r];

  // Route the memory response to the port at the head of the ID FIFO.
  always_comb begin
    if (have_out_s) begin
      mem_rsp_ready_o = head_s ? lsu_rsp_ready_i : ifu_rsp_ready_i;
      ifu_rsp_valid_o = mem_rsp_valid_i && !head_s;
      lsu_rsp_valid_o = mem_rsp_valid_i && head_s;
    end else begin
      // Nothing outstanding: swallow any response so the bus cannot hang.
      mem_rsp_ready_o = mem_rsp_valid_i;
      ifu_rsp_valid_o = 1'b0;
      lsu_rsp_valid_o = 1'b0;
    end
  end

  assign ifu_rsp_data_o  = mem_rsp_data_i;
  assign lsu_rsp_data_o  = mem_rsp_data_i;
  assign ifu_rsp_error_o = mem_rsp_error_i;
  assign lsu_rsp_error_o = mem_rsp_error_i;
  assign pop_s           = have_out_s && mem_rsp_valid_i && mem_rsp_ready_o;

  // Arbitration state: grant lock while stalled, round-robin history.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_r        <= 1'b0;
      locked_port_r <= 1'b0;
      rr_last_r     <= 1'b1;
    end else if (req_fire_s) begin
      lock_r        <= 1'b0;
      locked_port_r <= locked_port_r;
      rr_last_r     <= sel_s;
    end else if (mem_req_valid_o) begin
      lock_r        <= 1'b1;
      locked_port_r <= sel_s;
      rr_last_r     <= rr_last_r;
    end else begin
      lock_r        <= lock_r;
      locked_port_r <= locked_port_r;
      rr_last_r     <= rr_last_r;
    end
  end

  // Outstanding-transaction ID FIFO: push on request fire, pop on response fire.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (req_fire_s) begin
        id_fifo_r[wr_ptr_r] <= sel_s;
        wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({req_fire_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for responses that arrive with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      spurious_rsp_o <= 1'b0;
    end else if (mem_rsp_valid_i && !have_out_s) begin
      spurious_rsp_o <= 1'b1;
    end else begin
      spurious_rsp_o <= spurious_rsp_o;
    end
  end

endmodule
